// File: rtl/flash_byte_bridge_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : flash_byte_bridge_pkg                                         |
// | Desc   : Shared state encodings, size codes and byte helpers for the   |
// |          bus-to-byte-flash bridge.                                     |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
package flash_byte_bridge_pkg;

  // ST_HIT only becomes reachable when the word buffer is built in.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_GAP  = 3'd2,
    ST_ERR  = 3'd3,
    ST_HIT  = 3'd4
  } state_e;

  localparam logic [2:0] SZ_BYTE = 3'd1;
  localparam logic [2:0] SZ_HALF = 3'd2;
  localparam logic [2:0] SZ_WORD = 3'd4;
  localparam logic [2:0] FLASH_XFER_BYTE = 3'd1;

  function automatic logic size_ok(input logic [2:0] sz);
    return (sz == SZ_BYTE) || (sz == SZ_HALF) || (sz == SZ_WORD);
  endfunction

  // True when the access stays inside one 4-byte-aligned word.
  function automatic logic fits_word(input logic [1:0] off, input logic [2:0] sz);
    return (({1'b0, off} + sz) <= 3'd4);
  endfunction

  // Pull the requested bytes out of an aligned word, zero-extended.
  function automatic logic [31:0] extract_bytes(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  sz);
    logic [31:0] shifted;
    logic [31:0] mask;
    shifted = word >> {off, 3'b000};
    case (sz)
      SZ_BYTE: mask = 32'h0000_00FF;
      SZ_HALF: mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return shifted & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flash_byte_bridge_word_buffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : flash_word_buffer                                             |
// | Desc   : Single-entry aligned-word read buffer with hit detection and  |
// |          byte extraction. Used only when FLASH_WORD_BUFFER_EN is set.  |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module flash_word_buffer
  import flash_byte_bridge_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inval_i,
  input  logic            fill_i,
  input  logic [XLEN-3:0] fill_tag_i,
  input  logic [31:0]     fill_data_i,
  input  logic [XLEN-1:0] lookup_addr_i,
  input  logic [2:0]      lookup_size_i,
  output logic            hit_o,
  output logic [31:0]     hit_data_o
);

  logic            valid_q;
  logic [XLEN-3:0] tag_q;
  logic [31:0]     data_q;

  // Invalidation wins over a same-cycle fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (inval_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      data_q  <= fill_data_i;
    end
  end

  assign hit_o = valid_q && (tag_q == lookup_addr_i[XLEN-1:2]) &&
                 size_ok(lookup_size_i) &&
                 fits_word(lookup_addr_i[1:0], lookup_size_i);
  assign hit_data_o = extract_bytes(data_q, lookup_addr_i[1:0], lookup_size_i);

endmodule
`default_nettype wire

// File: rtl/flash_byte_bridge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : flash_byte_bridge                                             |
// | Desc   : Splits a 1/2/4-byte bus request into sequential single-byte   |
// |          flash handshakes, assembles reads little-endian, and reports  |
// |          bad sizes or unresponsive flash as an error response.         |
// |          Optional macro FLASH_WORD_BUFFER_EN adds a one-word read      |
// |          buffer.                                                       |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module flash_byte_bridge
  import flash_byte_bridge_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_size,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] digital_flash_addr,
  output logic            digital_flash_read_en,
  output logic            digital_flash_write_en,
  output logic [2:0]      digital_flash_byte_size,
  output logic [7:0]      digital_flash_wdata,
  input  logic [7:0]      digital_flash_data,
  input  logic            digital_flash_ready
);

  localparam logic [15:0] TMO_LAST = 16'(WAIT_TIMEOUT - 1);

  state_e          state_q;
  logic [1:0]      k_q;
  logic [15:0]     tmo_q;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      nbytes_q;
  logic            write_q;
  logic [31:0]     wdata_q;
  logic [31:0]     asm_q;

  logic            req_ready_q, resp_valid_q, resp_err_q;
  logic [XLEN-1:0] resp_rdata_q, fl_addr_q;
  logic            rd_en_q, wr_en_q;
  logic [2:0]      bsize_q;
  logic [7:0]      fl_wdata_q;

  logic [XLEN-1:0] start_addr_d, next_addr_d;
  logic [2:0]      start_nbytes_d, k_plus1_d;
  logic [1:0]      next_k_d;
  logic            more_d;
  logic [31:0]     rdata_final_d;

`ifdef FLASH_WORD_BUFFER_EN
  logic        fill_q;
  logic [1:0]  off_q;
  logic [2:0]  rsize_q;
  logic        fill_d, buf_inval_d, buf_fill_d, buf_hit;
  logic [31:0] buf_hit_data;

  flash_word_buffer #(.XLEN(XLEN)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .inval_i      (buf_inval_d),
    .fill_i       (buf_fill_d),
    .fill_tag_i   (addr_q[XLEN-1:2]),
    .fill_data_i  (asm_q),
    .lookup_addr_i(req_addr),
    .lookup_size_i(req_size),
    .hit_o        (buf_hit),
    .hit_data_o   (buf_hit_data)
  );
`endif

  // Start address/length of the flash burst and next-byte bookkeeping.
  always_comb begin
    start_addr_d   = req_addr;
    start_nbytes_d = req_size;
    k_plus1_d      = {1'b0, k_q} + 3'd1;
    next_k_d       = k_q + 2'd1;
    next_addr_d    = addr_q + XLEN'(next_k_d);
    more_d         = (k_plus1_d < nbytes_q);
    rdata_final_d  = asm_q;
`ifdef FLASH_WORD_BUFFER_EN
    // Reads that fit one aligned word fetch the whole word to fill the buffer.
    fill_d = !req_write && fits_word(req_addr[1:0], req_size);
    if (fill_d) begin
      start_addr_d   = {req_addr[XLEN-1:2], 2'b00};
      start_nbytes_d = SZ_WORD;
    end
    if (fill_q) rdata_final_d = extract_bytes(asm_q, off_q, rsize_q);
    buf_inval_d = ((state_q == ST_IDLE) && req_valid && req_write) ||
                  ((state_q == ST_WAIT) && !digital_flash_ready && (tmo_q == TMO_LAST));
    buf_fill_d  = (state_q == ST_GAP) && !more_d && fill_q;
`endif
  end

  // Main control FSM; every output is a register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      tmo_q        <= '0;
      addr_q       <= '0;
      nbytes_q     <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      asm_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      fl_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      bsize_q      <= '0;
      fl_wdata_q   <= '0;
`ifdef FLASH_WORD_BUFFER_EN
      fill_q       <= 1'b0;
      off_q        <= '0;
      rsize_q      <= '0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            write_q     <= req_write;
            wdata_q     <= req_wdata[31:0];
            k_q         <= '0;
            tmo_q       <= '0;
            asm_q       <= '0;
`ifdef FLASH_WORD_BUFFER_EN
            fill_q      <= fill_d;
            off_q       <= req_addr[1:0];
            rsize_q     <= req_size;
`endif
            if (!size_ok(req_size)) begin
              state_q <= ST_ERR;
`ifdef FLASH_WORD_BUFFER_EN
            end else if (!req_write && buf_hit) begin
              asm_q   <= buf_hit_data;
              state_q <= ST_HIT;
`endif
            end else begin
              addr_q     <= start_addr_d;
              nbytes_q   <= start_nbytes_d;
              fl_addr_q  <= start_addr_d;
              fl_wdata_q <= req_wdata[7:0];
              bsize_q    <= FLASH_XFER_BYTE;
              rd_en_q    <= !req_write;
              wr_en_q    <= req_write;
              state_q    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (digital_flash_ready) begin
            if (!write_q) asm_q[{k_q, 3'b000} +: 8] <= digital_flash_data;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            bsize_q <= '0;
            state_q <= ST_GAP;
          end else if (tmo_q == TMO_LAST) begin
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            bsize_q      <= '0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        ST_GAP: begin
          // Timeout budget is per byte.
          tmo_q <= '0;
          if (more_d) begin
            k_q        <= next_k_d;
            fl_addr_q  <= next_addr_d;
            fl_wdata_q <= wdata_q[{next_k_d, 3'b000} +: 8];
            bsize_q    <= FLASH_XFER_BYTE;
            rd_en_q    <= !write_q;
            wr_en_q    <= write_q;
            state_q    <= ST_WAIT;
          end else begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= write_q ? '0 : XLEN'(rdata_final_d);
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        ST_ERR: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_rdata_q <= '0;
          req_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end
        ST_HIT: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= XLEN'(asm_q);
          req_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready               = req_ready_q;
  assign resp_valid              = resp_valid_q;
  assign resp_err                = resp_err_q;
  assign resp_rdata              = resp_rdata_q;
  assign digital_flash_addr      = fl_addr_q;
  assign digital_flash_read_en   = rd_en_q;
  assign digital_flash_write_en  = wr_en_q;
  assign digital_flash_byte_size = bsize_q;
  assign digital_flash_wdata     = fl_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_flash_byte_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_flash_byte_bridge                                          |
// | Desc   : Directed self-checking bench for flash_byte_bridge with a     |
// |          behavioural byte-flash model (programmable ready delay).      |
// |          Expectations follow FLASH_WORD_BUFFER_EN when defined.        |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_flash_byte_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, fa;
  logic        fre, fwe, fready;
  logic [2:0]  fbs;
  logic [7:0]  fwd, fdata;

  always #5 clk = ~clk;

  flash_byte_bridge #(.XLEN(32), .WAIT_TIMEOUT(8)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_write              (req_write),
    .req_addr               (req_addr),
    .req_size               (req_size),
    .req_wdata              (req_wdata),
    .resp_valid             (resp_valid),
    .resp_rdata             (resp_rdata),
    .resp_err               (resp_err),
    .digital_flash_addr     (fa),
    .digital_flash_read_en  (fre),
    .digital_flash_write_en (fwe),
    .digital_flash_byte_size(fbs),
    .digital_flash_wdata    (fwd),
    .digital_flash_data     (fdata),
    .digital_flash_ready    (fready)
  );

  // Flash model: fixed read contents, ready after 'delay' enabled cycles.
  function automatic logic [7:0] rom(input logic [7:0] a);
    case (a)
      8'h10:   return 8'h78;
      8'h11:   return 8'h56;
      8'h12:   return 8'h34;
      8'h13:   return 8'h12;
      default: return a ^ 8'hA5;
    endcase
  endfunction

  int   delay = 0;
  logic stall = 1'b0;
  int   dcnt  = 0;
  assign fready = (fre | fwe) && !stall && (dcnt >= delay);
  assign fdata  = rom(fa[7:0]);

  int          rd_rises = 0, wr_rises = 0, proto_bad = 0, wn = 0;
  logic        fre_d = 1'b0, fwe_d = 1'b0;
  logic [31:0] wl_addr [0:15];
  logic [7:0]  wl_data [0:15];

  always @(posedge clk) begin
    dcnt  <= (fre | fwe) ? dcnt + 1 : 0;
    fre_d <= fre;
    fwe_d <= fwe;
    if (fre && !fre_d) rd_rises <= rd_rises + 1;
    if (fwe && !fwe_d) wr_rises <= wr_rises + 1;
    if ((fre | fwe) ? (fbs != 3'd1) : (fbs != 3'd0)) proto_bad <= proto_bad + 1;
    if (fre && fwe) proto_bad <= proto_bad + 1;
    if (fwe && fready) begin
      wl_addr[wn[3:0]] <= fa;
      wl_data[wn[3:0]] <= fwd;
      wn <= wn + 1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string pfx);
    chk({pfx, "_req_ready"},  32'(req_ready),  32'd1);
    chk({pfx, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({pfx, "_resp_err"},   32'(resp_err),   32'd0);
    chk({pfx, "_resp_rdata"}, resp_rdata,      32'd0);
    chk({pfx, "_flash_addr"}, fa,              32'd0);
    chk({pfx, "_read_en"},    32'(fre),        32'd0);
    chk({pfx, "_write_en"},   32'(fwe),        32'd0);
    chk({pfx, "_byte_size"},  32'(fbs),        32'd0);
    chk({pfx, "_wdata"},      32'(fwd),        32'd0);
  endtask

  // Present one request, take the acceptance edge, then count cycles to resp_valid.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output int lat);
    chk("req_ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz; req_wdata = wd;
    step();
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 64) begin
      step();
      lat++;
    end
  endtask

  int lat, r0, w0, w1, seen;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_size = '0; req_wdata = '0;
    repeat (3) step();
    chk_idle_zero("reset");
    rst = 1'b1;
    step();

    // Word read, zero-wait flash.
    r0 = rd_rises;
    xfer(1'b0, 32'h10, 3'd4, 32'h0, lat);
    chk("rd4_latency", 32'(lat), 32'd8);
    chk("rd4_rdata", resp_rdata, 32'h1234_5678);
    chk("rd4_err", 32'(resp_err), 32'd0);
    chk("rd4_read_rises", 32'(rd_rises - r0), 32'd4);
    step();
    chk("rd4_pulse_one_cycle", 32'(resp_valid), 32'd0);
    chk("rd4_rdata_hold", resp_rdata, 32'h1234_5678);

`ifdef FLASH_WORD_BUFFER_EN
    r0 = rd_rises;
    xfer(1'b0, 32'h10, 3'd4, 32'h0, lat);
    chk("hit_latency", 32'(lat), 32'd1);
    chk("hit_rdata", resp_rdata, 32'h1234_5678);
    chk("hit_read_rises", 32'(rd_rises - r0), 32'd0);
    step();
`endif

    // Halfword write.
    w0 = wn; w1 = wr_rises;
    xfer(1'b1, 32'h20, 3'd2, 32'h0000_AABB, lat);
    chk("wr2_latency", 32'(lat), 32'd4);
    chk("wr2_err", 32'(resp_err), 32'd0);
    chk("wr2_rdata", resp_rdata, 32'd0);
    chk("wr2_write_rises", 32'(wr_rises - w1), 32'd2);
    chk("wr2_byte0_addr", wl_addr[w0[3:0]], 32'h20);
    chk("wr2_byte0_data", 32'(wl_data[w0[3:0]]), 32'hBB);
    chk("wr2_byte1_addr", wl_addr[w0[3:0] + 4'd1], 32'h21);
    chk("wr2_byte1_data", 32'(wl_data[w0[3:0] + 4'd1]), 32'hAA);
    step();

    // Unaligned halfword read with 3 wait cycles per byte.
    delay = 3;
    r0 = rd_rises;
    xfer(1'b0, 32'h11, 3'd2, 32'h0, lat);
`ifdef FLASH_WORD_BUFFER_EN
    chk("rd2_latency", 32'(lat), 32'd20);
    chk("rd2_read_rises", 32'(rd_rises - r0), 32'd4);
`else
    chk("rd2_latency", 32'(lat), 32'd10);
    chk("rd2_read_rises", 32'(rd_rises - r0), 32'd2);
`endif
    chk("rd2_rdata", resp_rdata, 32'h0000_3456);
    chk("rd2_err", 32'(resp_err), 32'd0);
    delay = 0;
    step();

    // Illegal size: no flash access, error response.
    r0 = rd_rises; w1 = wr_rises;
    xfer(1'b0, 32'h30, 3'd3, 32'h0, lat);
    chk("badsz_resp_within_2", 32'(lat >= 1 && lat <= 2), 32'd1);
    chk("badsz_err", 32'(resp_err), 32'd1);
    chk("badsz_rdata", resp_rdata, 32'd0);
    chk("badsz_no_enables", 32'((rd_rises - r0) + (wr_rises - w1)), 32'd0);
    step();

    // Flash never ready: timeout after 8 wait cycles.
    stall = 1'b1;
    xfer(1'b0, 32'h40, 3'd1, 32'h0, lat);
    chk("tmo_latency", 32'(lat), 32'd8);
    chk("tmo_err", 32'(resp_err), 32'd1);
    chk("tmo_rdata", resp_rdata, 32'd0);
    chk("tmo_read_en_dropped", 32'(fre), 32'd0);
    stall = 1'b0;
    step();

    // Following request proceeds normally.
    xfer(1'b0, 32'h12, 3'd1, 32'h0, lat);
`ifdef FLASH_WORD_BUFFER_EN
    chk("post_tmo_latency", 32'(lat), 32'd8);
`else
    chk("post_tmo_latency", 32'(lat), 32'd2);
`endif
    chk("post_tmo_rdata", resp_rdata, 32'h34);
    chk("post_tmo_err", 32'(resp_err), 32'd0);
    step();

    // Reset during the second byte of a word read.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h50; req_size = 3'd4;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("mid_second_byte_en", 32'(fre), 32'd1);
    chk("mid_second_byte_addr", fa, 32'h51);
    rst = 1'b0;
    step();
    chk_idle_zero("midrst");
    rst = 1'b1;
    seen = 0;
    repeat (12) begin
      step();
      if (resp_valid) seen++;
    end
    chk("midrst_no_response", 32'(seen), 32'd0);

    // Bridge usable after reset; buffer must have been invalidated.
    xfer(1'b0, 32'h13, 3'd1, 32'h0, lat);
`ifdef FLASH_WORD_BUFFER_EN
    chk("post_rst_latency", 32'(lat), 32'd8);
`else
    chk("post_rst_latency", 32'(lat), 32'd2);
`endif
    chk("post_rst_rdata", resp_rdata, 32'h12);
    step();

    chk("byte_size_enable_protocol", 32'(proto_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
